// File: rtl/fetch_issue_if.sv
// Signal bundle between fetch_issue (master) and its imem / decode neighbours (slave).
// The misalign flag exists only when FETCH_MISALIGN_EN is defined.
interface fetch_issue_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            imem_done;
    logic [15:0]     instr;
    logic [PC_W-1:0] instr_pc2;
    logic            instr_valid;
    logic            instr_ready;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            halt;
    logic            halted;
`ifdef FETCH_MISALIGN_EN
    logic            misalign;

    modport master (
        output imem_req, imem_addr, instr, instr_pc2, instr_valid, halted, misalign,
        input  imem_rdata, imem_done, instr_ready, redirect, redirect_pc, halt
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_pc2, instr_valid, halted, misalign,
        output imem_rdata, imem_done, instr_ready, redirect, redirect_pc, halt
    );
`else
    modport master (
        output imem_req, imem_addr, instr, instr_pc2, instr_valid, halted,
        input  imem_rdata, imem_done, instr_ready, redirect, redirect_pc, halt
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_pc2, instr_valid, halted,
        output imem_rdata, imem_done, instr_ready, redirect, redirect_pc, halt
    );
`endif
endinterface

// File: rtl/fetch_issue.sv
// Fetch front end: PC, one-outstanding imem read, DEPTH-entry buffer to decode; FETCH_MISALIGN_EN halts on odd targets.
// imem_done in cycle N -> instr_valid in N+1; reads stop when buffer+outstanding would exceed DEPTH.
module fetch_issue #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input logic           clk,
    input logic           rst_n,
    fetch_issue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef logic [PC_W-1:0] pc_t;
    typedef struct packed {
        logic [15:0] dat;
        pc_t         pc2;
    } entry_t;
    typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HALT} state_t;

    state_t        state_q, state_d;
    pc_t           pc_q, pc_d;
    logic          squash_q, squash_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
`ifdef FETCH_MISALIGN_EN
    logic          misalign_q, misalign_d;
`endif

    logic   valid, pop, push, req, done_ok;
    logic   halt_go, redir_go, bad_target;
    pc_t    target;
    entry_t head;

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != '0) && (state_q != ST_HALT);
    assign pop   = valid && bus.instr_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
`ifdef FETCH_MISALIGN_EN
        misalign_d = misalign_q;
`endif

        target = bus.redirect_pc;
`ifdef FETCH_MISALIGN_EN
        bad_target = target[0];
`else
        target[0]  = 1'b0;
        bad_target = 1'b0;
`endif
        // A halt only counts when decode actually consumes the HALT word.
        halt_go  = bus.halt && pop;
        redir_go = bus.redirect && (state_q != ST_HALT) && !halt_go;
        done_ok  = (state_q == ST_WAIT) && bus.imem_done;
        req      = rst_n && (state_q == ST_REQ) && (count_q < FULL) && !bus.redirect && !halt_go;
        push     = done_ok && !squash_q && !bus.redirect && !halt_go;

        if (halt_go || (redir_go && bad_target)) begin
            state_d  = ST_HALT;
            squash_d = 1'b0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
`ifdef FETCH_MISALIGN_EN
            misalign_d = misalign_q | (redir_go && bad_target);
`endif
        end else if (redir_go) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = target;
            // The in-flight read still has to complete before the next one may issue.
            if ((state_q == ST_WAIT) && !bus.imem_done) begin
                squash_d = 1'b1;
            end else begin
                squash_d = 1'b0;
                state_d  = ST_REQ;
            end
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            // pc_q already points one word past the outstanding read address.
            if (push) begin
                mem_d[wr_ptr_q] = '{dat: bus.imem_rdata, pc2: pc_q};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (req) begin
                state_d = ST_WAIT;
                pc_d    = pc_q + pc_t'(2);
            end
            if (done_ok) begin
                state_d  = ST_REQ;
                squash_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef FETCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
`ifdef FETCH_MISALIGN_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? head.dat : '0;
    assign bus.instr_pc2   = valid ? head.pc2 : '0;
    assign bus.halted      = (state_q == ST_HALT);
`ifdef FETCH_MISALIGN_EN
    assign bus.misalign    = misalign_q;
`endif

endmodule
